// File: rtl/s2p_pkg.sv
// Shared widths, FSM state encodings and the saturation helper for speed2phase.
// Q9.10 phase words are 19 bits wide. Saturation clamps to [-2^18, 2^18-1].
package s2p_pkg;

   localparam int SPEED_W    = 16;
   localparam int PHASE_W    = 19;
   localparam int PHASE_FRAC = 10;
   localparam int N_W        = 4;
   localparam int SAT_W      = 34;

   localparam int             STATE_W = 3;
   localparam logic [2:0]     S_IDLE  = 3'd0;
   localparam logic [2:0]     S_CALC  = 3'd1;
   localparam logic [2:0]     S_EMIT  = 3'd2;
   localparam logic [2:0]     S_WAIT  = 3'd3;
   localparam logic [2:0]     S_DONE  = 3'd4;

   localparam logic signed [PHASE_W-1:0] PHASE_MAX = 19'sh3FFFF;
   localparam logic signed [PHASE_W-1:0] PHASE_MIN = 19'sh40000;

   // Clamp a wide signed intermediate into the Q9.10 range. Out-of-range values never wrap.
   function automatic logic signed [PHASE_W-1:0] sat_phase(input logic signed [SAT_W-1:0] v);
      if (v > PHASE_MAX)      return PHASE_MAX;
      else if (v < PHASE_MIN) return PHASE_MIN;
      else                    return v[PHASE_W-1:0];
   endfunction

endpackage

// File: rtl/s2p_scale.sv
// Combinational speed -> phase conversion.
// Computes a 16x17 signed multiply, then an arithmetic right shift by SHIFT, then saturation to 19 bits.
module s2p_scale
   import s2p_pkg::*;
#(
   parameter logic [16:0] GAIN  = 17'd1024,
   parameter int          SHIFT = PHASE_FRAC
)(
   input  logic signed [SPEED_W-1:0] speed,
   output logic signed [PHASE_W-1:0] phase
);

   logic signed [32:0] product;
   logic signed [32:0] shifted;

   // Scale, shift (floor toward -inf) and clamp the requested speed.
   always_comb begin
      // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
      product = 33'(speed) * 33'($signed({1'b0, GAIN}));
      shifted = product >>> SHIFT;
      phase   = sat_phase(34'(shifted));
   end

endmodule

// File: rtl/speed2phase.sv
// speed2phase: burst generator for the phase-difference interface consumed by phase2speed.
// It latches a signed speed and a sample count, converts the speed to a Q9.10 phase,
// then emits N samples, each qualified by a 1-cycle data_rdy strobe, INTERVAL cycles apart.
// Optional feature: define SPEED2PHASE_DITHER_EN to add LFSR dither of DITHER_W LSBs per sample.
module speed2phase
   import s2p_pkg::*;
#(
   parameter logic [16:0] GAIN     = 17'd1024,
   parameter int          SHIFT    = PHASE_FRAC,
   parameter int          INTERVAL = 20,
   parameter int          DITHER_W = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] in_speed,
   input  logic [3:0]  N,
   output logic        busy,
   output logic        done,
   output logic        data_rdy,
   output logic [18:0] out_phasediff
);

   // The interval counter holds INTERVAL-2 at most.
   localparam int                ICNT_W    = (INTERVAL > 2) ? $clog2(INTERVAL - 1) : 1;
   localparam logic [ICNT_W-1:0] ICNT_LOAD = ICNT_W'(INTERVAL - 2);

   logic [STATE_W-1:0]        state;
   logic signed [SPEED_W-1:0] speed_q;
   logic [N_W-1:0]            n_q;
   logic [N_W-1:0]            smp_cnt;
   logic [ICNT_W-1:0]         icnt;
   logic signed [PHASE_W-1:0] calc_phase;
   logic signed [PHASE_W-1:0] emit_value;

   s2p_scale #(.GAIN(GAIN), .SHIFT(SHIFT)) u_scale (
      .speed (speed_q),
      .phase (calc_phase)
   );

`ifdef SPEED2PHASE_DITHER_EN
   localparam logic signed [SAT_W-1:0] DITH_BIAS = 34'sd1 <<< (DITHER_W - 1);

   logic [15:0]               lfsr;
   logic signed [PHASE_W-1:0] phase_q;
   logic signed [SAT_W-1:0]   dith_sum;

   // Dithered sample: the base phase plus an LFSR offset in [-2^(DITHER_W-1), 2^(DITHER_W-1)-1], re-saturated.
   always_comb begin
      dith_sum   = (state == S_CALC) ? 34'(calc_phase) : 34'(phase_q);
      dith_sum   = dith_sum + $signed({{(SAT_W-DITHER_W){1'b0}}, lfsr[DITHER_W-1:0]}) - DITH_BIAS;
      emit_value = sat_phase(dith_sum);
   end

   // Keep the undithered base phase. Step the LFSR (taps 16,14,13,11) on every entry into EMIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr    <= 16'hACE1;
         phase_q <= '0;
      end else begin
         if (state == S_CALC) phase_q <= calc_phase;
         if (state == S_CALC || (state == S_WAIT && icnt == '0))
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end
`else
   // Without dither, every sample in a burst is the CALC value.
   always_comb emit_value = calc_phase;
`endif

   // Burst FSM. Outputs are registered, so each strobe lines up with its state's cycle.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state uses non-blocking assignments, and the asynchronous reset clears everything immediately.
      if (!reset) begin
         state         <= S_IDLE;
         speed_q       <= '0;
         n_q           <= '0;
         smp_cnt       <= '0;
         icnt          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         data_rdy      <= 1'b0;
         out_phasediff <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  speed_q <= $signed(in_speed);
                  n_q     <= (N == '0) ? N_W'(1) : N;
                  smp_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               out_phasediff <= emit_value;
               data_rdy      <= 1'b1;
               state         <= S_EMIT;
            end
            S_EMIT: begin
               // The last sample goes straight to DONE, so done follows the final strobe by one cycle.
               data_rdy <= 1'b0;
               smp_cnt  <= smp_cnt + 1'b1;
               icnt     <= ICNT_LOAD;
               if (smp_cnt + 1'b1 == n_q) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (icnt == '0) begin
`ifdef SPEED2PHASE_DITHER_EN
                  out_phasediff <= emit_value;
`endif
                  data_rdy <= 1'b1;
                  state    <= S_EMIT;
               end else begin
                  icnt <= icnt - 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_speed2phase.sv
// Testbench for speed2phase.
// Two instances are used: default GAIN (1024), and GAIN=32768 for saturation.
// Expected phases come from integer arithmetic on the speed request.
// Expected timing comes from the strobe schedule, with cycle 0 being the cycle in which start is high.
module tb_speed2phase;

   localparam int INTERVAL = 20;
   localparam int PMAX     = 262143;
   localparam int PMIN     = -262144;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [15:0] in_speed = '0;
   logic [3:0]  n_in = '0;
   logic        busy_a, done_a, rdy_a, busy_b, done_b, rdy_b;
   logic [18:0] ph_a, ph_b;
   logic        sel_b = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   speed2phase #(.GAIN(17'd1024)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .in_speed(in_speed), .N(n_in),
      .busy(busy_a), .done(done_a), .data_rdy(rdy_a), .out_phasediff(ph_a)
   );

   speed2phase #(.GAIN(17'd32768)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_speed(in_speed), .N(n_in),
      .busy(busy_b), .done(done_b), .data_rdy(rdy_b), .out_phasediff(ph_b)
   );

   wire        o_busy = sel_b ? busy_b : busy_a;
   wire        o_done = sel_b ? done_b : done_a;
   wire        o_rdy  = sel_b ? rdy_b  : rdy_a;
   wire [18:0] o_ph   = sel_b ? ph_b   : ph_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input bit b, input logic v);
      if (b) start_b = v;
      else   start_a = v;
   endtask

   // speed * gain / 2^10, rounded toward -inf, then clamped to the Q9.10 range.
   function automatic logic [18:0] model_phase(input int speed, input longint gain);
      longint p, q;
      p = longint'(speed) * gain;
      q = p / 1024;
      if (p < 0 && (p % 1024) != 0) q = q - 1;
      if (q > PMAX) q = PMAX;
      if (q < PMIN) q = PMIN;
      return q[18:0];
   endfunction

   // Runs one burst. ghost1/ghost2 are cycle indices where a stray start is pulsed with different inputs.
   task automatic run_burst(input bit b, input logic [15:0] spd, input logic [3:0] n,
                            input int ghost1, input int ghost2, input bit chk_vary, input string tag);
      int          n_eff, done_idx, strobes, bad_timing, bad_val, busy_len, v, first, lo, hi, e;
      bit          exp_rdy, differ;
      logic [18:0] expv;
      n_eff      = (n == 0) ? 1 : int'(n);
      done_idx   = 2 + (n_eff - 1) * INTERVAL + 1;
      expv       = model_phase(int'($signed(spd)), b ? 64'd32768 : 64'd1024);
      e          = int'($signed(expv));
      lo         = (e - 2 < PMIN) ? PMIN : e - 2;
      hi         = (e + 1 > PMAX) ? PMAX : e + 1;
      strobes    = 0; bad_timing = 0; bad_val = 0; busy_len = 1; first = 0; differ = 0;
      sel_b      = b;
      in_speed   = spd;
      n_in       = n;
      set_start(b, 1'b1);
      tick();
      for (int idx = 1; idx <= done_idx + 1; idx++) begin
         if (idx == ghost1 || idx == ghost2) begin
            in_speed = ~spd;
            n_in     = n + 4'd3;
            set_start(b, 1'b1);
         end else begin
            set_start(b, 1'b0);
         end
         exp_rdy = (idx >= 2) && ((idx - 2) % INTERVAL == 0) && ((idx - 2) / INTERVAL < n_eff);
         if (o_rdy !== exp_rdy || o_done !== (idx == done_idx) || o_busy !== (idx <= done_idx))
            bad_timing++;
         if (o_busy === 1'b1) busy_len++;
         if (o_rdy === 1'b1) strobes++;
`ifdef SPEED2PHASE_DITHER_EN
         if (o_rdy === 1'b1) begin
            v = int'($signed(o_ph));
            if (v < lo || v > hi) bad_val++;
            if (strobes == 1) first = v;
            else if (v != first) differ = 1'b1;
         end
`else
         if (idx >= 2 && o_ph !== expv) bad_val++;
`endif
         if (idx <= done_idx) tick();
      end
      check({tag, " strobes"}, strobes, n_eff);
      check({tag, " timing"}, bad_timing, 0);
      check({tag, " busy_len"}, busy_len, 2 + (n_eff - 1) * INTERVAL + 2);
      check({tag, " values"}, bad_val, 0);
`ifdef SPEED2PHASE_DITHER_EN
      if (chk_vary) check({tag, " vary"}, differ, 1'b1);
`else
      if (chk_vary) check({tag, " final"}, o_ph, expv);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int seen, done_cnt;
      logic [15:0] spd;
      logic [3:0]  n;

      // Reset state, with start pulsed while reset is held.
      start_a = 1'b1;
      #12;
      check("reset busy", busy_a, 1'b0);
      check("reset rdy", rdy_a, 1'b0);
      check("reset done", done_a, 1'b0);
      check("reset phase", ph_a, 19'h0);
      start_a = 1'b0;
      #3 reset = 1'b1;
      tick();

      // 1: speed 1024, N=4.
      run_burst(1'b0, 16'd1024, 4'd4, -1, -1, 1'b1, "t1");
`ifndef SPEED2PHASE_DITHER_EN
      check("t1 const", ph_a, 19'h00400);
`endif
      // 2: speed -1024, N=8, started in the cycle right after the previous done.
      run_burst(1'b0, -16'sd1024, 4'd8, -1, -1, 1'b0, "t2");
`ifndef SPEED2PHASE_DITHER_EN
      check("t2 const", ph_a, 19'h7FC00);
`endif
      // 3: saturation at both ends with GAIN=32768.
      run_burst(1'b1, 16'h7FFF, 4'd1, -1, -1, 1'b0, "t3hi");
`ifndef SPEED2PHASE_DITHER_EN
      check("t3 max", ph_b, 19'h3FFFF);
`endif
      run_burst(1'b1, 16'h8000, 4'd1, -1, -1, 1'b0, "t3lo");
`ifndef SPEED2PHASE_DITHER_EN
      check("t3 min", ph_b, 19'h40000);
`endif
      // 4: N=0 becomes a single strobe; stray starts during busy and on done are ignored.
      run_burst(1'b0, 16'd777, 4'd0, 1, 3, 1'b0, "t4n0");
      run_burst(1'b0, 16'd500, 4'd2, 5, 23, 1'b0, "t4ign");

      // 5: reset asserted mid-burst, after the second strobe.
      sel_b = 1'b0; in_speed = 16'd3000; n_in = 4'd8; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      seen = 0;
      for (int k = 0; k < 100 && seen < 2; k++) begin
         if (rdy_a === 1'b1) seen++;
         if (seen < 2) tick();
      end
      check("t5 strobes before reset", seen, 2);
      check("t5 phase before reset", ph_a, model_phase(3000, 1024));
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("t5 busy async", busy_a, 1'b0);
      check("t5 rdy async", rdy_a, 1'b0);
      check("t5 done async", done_a, 1'b0);
      check("t5 phase async", ph_a, 19'h0);
      done_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done_a !== 1'b0 || busy_a !== 1'b0) done_cnt++;
      end
      check("t5 quiet in reset", done_cnt, 0);
      #3 reset = 1'b1;
      tick();
      run_burst(1'b0, 16'd2048, 4'd2, -1, -1, 1'b1, "t5fresh");

      // 6: speed 1024, N=8. With dither the samples vary within range; without it every sample is exact.
      run_burst(1'b0, 16'd1024, 4'd8, -1, -1, 1'b1, "t6");

      // Randomized bursts on both gains.
      for (int r = 0; r < 8; r++) begin
         spd = (r % 4 < 2) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
         n   = 4'($urandom_range(1, 3));
         run_burst(r[0], spd, n, -1, -1, 1'b0, $sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
